// File: rtl/mux8_pkg.sv
// Shared definitions for the registered 8:1 selector.
// Select encoding and input count used by the comb stage and the top.
package mux8_pkg;

    localparam int SEL_W  = 3;
    localparam int NUM_IN = 8;

    typedef logic [SEL_W-1:0] sel_t;

    localparam sel_t SEL_A0 = 3'd0;
    localparam sel_t SEL_A1 = 3'd1;
    localparam sel_t SEL_A2 = 3'd2;
    localparam sel_t SEL_A3 = 3'd3;
    localparam sel_t SEL_A4 = 3'd4;
    localparam sel_t SEL_A5 = 3'd5;
    localparam sel_t SEL_A6 = 3'd6;
    localparam sel_t SEL_A7 = 3'd7;

endpackage

// File: rtl/mux8_comb.sv
// Purely combinational 8:1 WIDTH-bit selector.
// Every select code maps to exactly one input; no priority chain.
module mux8_comb
    import mux8_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] a2,
    input  logic [WIDTH-1:0] a3,
    input  logic [WIDTH-1:0] a4,
    input  logic [WIDTH-1:0] a5,
    input  logic [WIDTH-1:0] a6,
    input  logic [WIDTH-1:0] a7,
    input  sel_t             sel,
    output logic [WIDTH-1:0] d
);

    always_comb begin
        d = '0;
        unique case (sel)
            SEL_A0: d = a0;
            SEL_A1: d = a1;
            SEL_A2: d = a2;
            SEL_A3: d = a3;
            SEL_A4: d = a4;
            SEL_A5: d = a5;
            SEL_A6: d = a6;
            SEL_A7: d = a7;
        endcase
    end

endmodule

// File: rtl/mux8_reg.sv
// Registered 8:1 selector: comb select followed by an enabled,
// asynchronously reset output flop so y is glitch-free and reset-defined.
module mux8_reg
    import mux8_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] a2,
    input  logic [WIDTH-1:0] a3,
    input  logic [WIDTH-1:0] a4,
    input  logic [WIDTH-1:0] a5,
    input  logic [WIDTH-1:0] a6,
    input  logic [WIDTH-1:0] a7,
    input  logic             s0,
    input  logic             s1,
    input  logic             s2,
    output logic [WIDTH-1:0] y
);

    sel_t             sel;
    logic [WIDTH-1:0] d_next;

    assign sel = {s2, s1, s0};

    mux8_comb #(
        .WIDTH (WIDTH)
    ) u_comb (
        .a0  (a0),
        .a1  (a1),
        .a2  (a2),
        .a3  (a3),
        .a4  (a4),
        .a5  (a5),
        .a6  (a6),
        .a7  (a7),
        .sel (sel),
        .d   (d_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y <= '0;
        end else if (en) begin
            y <= d_next;
        end
    end

endmodule

// File: tb/tb_mux8_reg.sv
// Directed self-checking bench for mux8_reg at WIDTH=8.
// Inputs change 1ns after each rising edge; y is checked there too.
module tb_mux8_reg;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         en;
    logic [W-1:0] a [8];
    logic         s0, s1, s2;
    logic [W-1:0] y;

    int pass_cnt;
    int total_cnt;

    mux8_reg #(
        .WIDTH (W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .a0    (a[0]),
        .a1    (a[1]),
        .a2    (a[2]),
        .a3    (a[3]),
        .a4    (a[4]),
        .a5    (a[5]),
        .a6    (a[6]),
        .a7    (a[7]),
        .s0    (s0),
        .s1    (s1),
        .s2    (s2),
        .y     (y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_sel(input int k);
        logic [2:0] v;
        v  = k[2:0];
        s0 = v[0];
        s1 = v[1];
        s2 = v[2];
    endtask

    task automatic set_all(input logic [W-1:0] v);
        for (int i = 0; i < 8; i++) a[i] = v;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        set_all(8'h01);
        set_sel(7);
        en    = 1'b1;
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if (y !== 8'h00)
            $display("FAIL reset_immediate: y=%h expected=%h", y, 8'h00);
        else pass_cnt++;
        for (int c = 0; c < 3; c++) begin
            en = c[0];
            tick();
            total_cnt++;
            if (y !== 8'h00)
                $display("FAIL reset_hold cyc%0d: y=%h expected=%h", c, y, 8'h00);
            else pass_cnt++;
        end
        en    = 1'b1;
        rst_n = 1'b1;
        #2;
        total_cnt++;
        if (y !== 8'h00)
            $display("FAIL reset_release_pre_edge: y=%h expected=%h", y, 8'h00);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (y !== 8'h01)
            $display("FAIL reset_first_capture: y=%h expected=%h", y, 8'h01);
        else pass_cnt++;
    endtask

    task automatic test_zero_sweep();
        set_all(8'h00);
        en = 1'b1;
        for (int k = 0; k < 8; k++) begin
            set_sel(k);
            tick();
            total_cnt++;
            if (y !== 8'h00)
                $display("FAIL zero_sweep sel%0d: y=%h expected=%h", k, y, 8'h00);
            else pass_cnt++;
        end
    endtask

    task automatic test_onehot();
        logic [W-1:0] exp;
        en = 1'b1;
        for (int j = 0; j < 8; j++) begin
            set_all(8'h00);
            a[j] = 8'h01;
            for (int k = 0; k < 8; k++) begin
                set_sel(k);
                tick();
                exp = (k == j) ? 8'h01 : 8'h00;
                total_cnt++;
                if (y !== exp)
                    $display("FAIL onehot a%0d sel%0d: y=%h expected=%h",
                             j, k, y, exp);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_enable_hold();
        set_all(8'h00);
        a[3] = 8'h01;
        set_sel(3);
        en = 1'b1;
        tick();
        total_cnt++;
        if (y !== 8'h01)
            $display("FAIL hold_capture: y=%h expected=%h", y, 8'h01);
        else pass_cnt++;
        en   = 1'b0;
        a[3] = 8'h00;
        a[5] = 8'h55;
        set_sel(5);
        for (int c = 0; c < 4; c++) begin
            tick();
            total_cnt++;
            if (y !== 8'h01)
                $display("FAIL hold cyc%0d: y=%h expected=%h", c, y, 8'h01);
            else pass_cnt++;
        end
        en = 1'b1;
        tick();
        total_cnt++;
        if (y !== 8'h55)
            $display("FAIL hold_release: y=%h expected=%h", y, 8'h55);
        else pass_cnt++;
    endtask

    task automatic test_latency_isolation();
        set_all(8'h00);
        a[2] = 8'hA2;
        a[6] = 8'hC6;
        en   = 1'b1;
        set_sel(2);
        tick();
        total_cnt++;
        if (y !== 8'hA2)
            $display("FAIL latency_first: y=%h expected=%h", y, 8'hA2);
        else pass_cnt++;
        set_sel(6);
        #2;
        total_cnt++;
        if (y !== 8'hA2)
            $display("FAIL latency_mid_cycle: y=%h expected=%h", y, 8'hA2);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (y !== 8'hC6)
            $display("FAIL latency_after_edge: y=%h expected=%h", y, 8'hC6);
        else pass_cnt++;
        for (int c = 0; c < 4; c++) begin
            for (int i = 0; i < 8; i++)
                if (i != 6) a[i] = W'($urandom);
            if (c == 3) begin
                a[0] = 'x;
                a[7] = 'z;
            end
            tick();
            total_cnt++;
            if (y !== 8'hC6)
                $display("FAIL isolation cyc%0d: y=%h expected=%h", c, y, 8'hC6);
            else pass_cnt++;
        end
    endtask

    task automatic test_async_reset();
        set_all(8'h00);
        a[1] = 8'h01;
        set_sel(1);
        en = 1'b1;
        tick();
        total_cnt++;
        if (y !== 8'h01)
            $display("FAIL async_pre: y=%h expected=%h", y, 8'h01);
        else pass_cnt++;
        #2;
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if (y !== 8'h00)
            $display("FAIL async_clear: y=%h expected=%h", y, 8'h00);
        else pass_cnt++;
        tick();
        rst_n = 1'b1;
        tick();
        total_cnt++;
        if (y !== 8'h01)
            $display("FAIL async_recapture: y=%h expected=%h", y, 8'h01);
        else pass_cnt++;
    endtask

    task automatic test_width8();
        logic [W-1:0] exp;
        for (int i = 0; i < 8; i++) a[i] = 8'h10 + 8'(i);
        en = 1'b1;
        for (int k = 7; k >= 0; k--) begin
            set_sel(k);
            tick();
            exp = 8'h10 + 8'(k);
            total_cnt++;
            if (y !== exp)
                $display("FAIL width8 sel%0d: y=%h expected=%h", k, y, exp);
            else pass_cnt++;
        end
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        rst_n     = 1'b0;
        en        = 1'b0;
        set_all(8'h00);
        set_sel(0);
        test_reset();
        test_zero_sweep();
        test_onehot();
        test_enable_hold();
        test_latency_isolation();
        test_async_reset();
        test_width8();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/mux8_reg.md
Name: mux8_reg

Overview:
- Registered 8:1 selector with individual select bits s0/s1/s2 and eight discrete data inputs a0..a7.
- Picks one data input per cycle and drives it on y from a flop.
- Used as a leaf datapath selector wherever a clean, glitch-free, reset-defined output is required.
- Single clock domain; no handshakes.

Parameters:
- WIDTH, 1, bit width of each data input a0..a7 and of output y (legal range 1..64).

Ports:
- clk  input  1  rising-edge clock, sole clock of the block
- rst_n  input  1  asynchronous active-low reset
- en  input  1  capture enable; y updates only when en=1
- a0  input  WIDTH  data input, selected when {s2,s1,s0}=3'b000
- a1  input  WIDTH  data input, selected at 3'b001
- a2  input  WIDTH  data input, selected at 3'b010
- a3  input  WIDTH  data input, selected at 3'b011
- a4  input  WIDTH  data input, selected at 3'b100
- a5  input  WIDTH  data input, selected at 3'b101
- a6  input  WIDTH  data input, selected at 3'b110
- a7  input  WIDTH  data input, selected at 3'b111
- s0  input  1  select bit 0 (LSB)
- s1  input  1  select bit 1
- s2  input  1  select bit 2 (MSB)
- y  output  WIDTH  registered selected data

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Select index sel = {s2,s1,s0}, unsigned 0..7; sel=k chooses ak.
- Combinational stage: d_next = a[sel]. Purely combinational, with no latches and no priority logic. Every sel value is decoded; there is no default-to-X.
- Register stage: on rising clk with rst_n=1 and en=1, y <= d_next. With en=0, y holds its value.
- Latency: exactly 1 clock from a0..a7/s*/en sampled at an edge to y valid after that edge. No combinational path from inputs to y.
- Reset:
  - rst_n=0 forces y to all-zeros immediately, independent of clk.
  - While rst_n=0, y stays 0 regardless of en, select or data.
  - First capture occurs at the first rising clk after rst_n deasserts, provided en=1.
  - Reset asserted mid-operation discards the held value; y returns to 0 at once.
- Simultaneous changes of select and data before an edge: the value captured is a[sel] of the values present at that edge.
- All non-selected inputs are don't-care; toggling them must never change y.
- X/Z on a non-selected input must not propagate to y.

Decomposition:
- Shared package mux8_pkg:
  - localparam SEL_W = 3 and NUM_IN = 8.
  - Typedef sel_t as logic [SEL_W-1:0].
  - Named constants SEL_A0..SEL_A7 = 3'd0..3'd7.
- One sub-module, mux8_comb: purely combinational 8:1 WIDTH-bit selector (a0..a7, sel -> d).
- mux8_reg instantiates mux8_comb, concatenates {s2,s1,s0} into sel_t, and adds the enabled async-reset output flop.

Test Plan:
- Reset: rst_n=0 with all a*=1, sel=7, en=1 -> y=0 immediately and across 3 clocks. Release rst_n -> y=1 after the next edge.
- All-zero data sweep: a0..a7=0, en=1, sel stepped 0..7, one per clock -> y=0 on every cycle.
- One-hot sweep: a7=1, others 0, sel stepped 0..7 -> y=0 for sel 0..6, y=1 only after the edge sampling sel=7 (3'b111). Repeat for each ak to check the sel-to-input mapping.
- Enable hold: capture y=1 (a3=1, sel=3), then en=0 and change a3=0 and sel=5 for 4 clocks -> y stays 1. Set en=1 -> y=a5 after one edge.
- Latency and isolation: change sel between edges -> y changes only at the next rising edge. Toggle non-selected inputs each cycle -> y unchanged.
- Async reset mid-stream: y=1, assert rst_n=0 between edges -> y=0 before the next clk edge. WIDTH=8 variant: a0..a7 = 8'h10..8'h17, sel=k -> y = 8'h10+k.
